// File: rtl/lda_pkg.sv
// Shared types and constants for the line setup controller.
// Holds the FSM encoding, datapath widths and watchdog limit.
package lda_pkg;

  localparam int COORD_W = 9;
  localparam int CNT_W   = 16;
  localparam int WD_W    = 12;

  localparam logic [WD_W-1:0] WD_LIMIT = 12'd4095;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [CNT_W-1:0]   count_t;
  typedef logic [WD_W-1:0]    wd_t;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CAPTURE   = 3'd1,
    S_ABS       = 3'd2,
    S_SWAP      = 3'd3,
    S_START     = 3'd4,
    S_WAIT_DONE = 3'd5,
    S_RELEASE   = 3'd6
  } state_e;

  function automatic coord_t abs_diff(
    input coord_t a,
    input coord_t b
  );
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/lda_normalise.sv
// Steep detection and endpoint normalisation for the line engine.
// Purely combinational; the parent registers the results.
module lda_normalise
  import lda_pkg::*;
(
  input  coord_t x0,
  input  coord_t y0,
  input  coord_t x1,
  input  coord_t y1,
  input  coord_t dx,
  input  coord_t dy,
  output logic   steep,
  output coord_t nx0,
  output coord_t ny0,
  output coord_t nx1,
  output coord_t ny1
);

  coord_t ax0, ay0, ax1, ay1;

  // Transpose for steep lines, then order endpoints by x
  always_comb begin
    steep = (dy > dx);
    ax0 = steep ? y0 : x0;
    ay0 = steep ? x0 : y0;
    ax1 = steep ? y1 : x1;
    ay1 = steep ? x1 : y1;
    nx0 = ax0;
    ny0 = ay0;
    nx1 = ax1;
    ny1 = ay1;
    if (ax0 > ax1) begin
      nx0 = ax1;
      ny0 = ay1;
      nx1 = ax0;
      ny1 = ay0;
    end
  end

endmodule

// File: rtl/line_setup_ctrl.sv
// Line setup controller: captures a request, normalises it and
// drives the line engine. Optional watchdog: LINE_SETUP_TIMEOUT_EN.
module line_setup_ctrl
  import lda_pkg::*;
(
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  output logic [COORD_W-1:0] realx0,
  output logic [COORD_W-1:0] realy0,
  output logic [COORD_W-1:0] realx1,
  output logic [COORD_W-1:0] realy1,
  output logic               steep,
  output logic               stt,
  input  logic               done,
  output logic               busy,
  output logic [CNT_W-1:0]   lines_drawn,
  output logic               timeout
);

  state_e state_q, state_d;
  coord_t cx0_q, cy0_q, cx1_q, cy1_q;
  coord_t cx0_d, cy0_d, cx1_d, cy1_d;
  coord_t dx_q, dy_q, dx_d, dy_d;
  coord_t rx0_q, ry0_q, rx1_q, ry1_q;
  coord_t rx0_d, ry0_d, rx1_d, ry1_d;
  logic   steep_q, steep_d;
  count_t lines_q, lines_d;

  logic   n_steep;
  coord_t n_x0, n_y0, n_x1, n_y1;

`ifdef LINE_SETUP_TIMEOUT_EN
  wd_t  wd_q, wd_d;
  logic to_q, to_d;
`endif

  lda_normalise u_norm (
    .x0    (cx0_q),
    .y0    (cy0_q),
    .x1    (cx1_q),
    .y1    (cy1_q),
    .dx    (dx_q),
    .dy    (dy_q),
    .steep (n_steep),
    .nx0   (n_x0),
    .ny0   (n_y0),
    .nx1   (n_x1),
    .ny1   (n_y1)
  );

  // Next-state and datapath updates for the setup sequence
  always_comb begin
    state_d = state_q;
    cx0_d   = cx0_q;
    cy0_d   = cy0_q;
    cx1_d   = cx1_q;
    cy1_d   = cy1_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    rx0_d   = rx0_q;
    ry0_d   = ry0_q;
    rx1_d   = rx1_q;
    ry1_d   = ry1_q;
    steep_d = steep_q;
    lines_d = lines_q;
`ifdef LINE_SETUP_TIMEOUT_EN
    wd_d    = wd_q;
    to_d    = to_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          cx0_d   = x0;
          cy0_d   = y0;
          cx1_d   = x1;
          cy1_d   = y1;
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: state_d = S_ABS;
      S_ABS: begin
        dx_d    = abs_diff(cx1_q, cx0_q);
        dy_d    = abs_diff(cy1_q, cy0_q);
        state_d = S_SWAP;
      end
      S_SWAP: begin
        rx0_d   = n_x0;
        ry0_d   = n_y0;
        rx1_d   = n_x1;
        ry1_d   = n_y1;
        steep_d = n_steep;
        state_d = S_START;
      end
      S_START: begin
`ifdef LINE_SETUP_TIMEOUT_EN
        wd_d    = '0;
`endif
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (done) begin
          lines_d = lines_q + 16'd1;
          state_d = S_RELEASE;
        end
`ifdef LINE_SETUP_TIMEOUT_EN
        else if (wd_q == WD_LIMIT - 12'd1) begin
          to_d    = 1'b1;
          state_d = S_RELEASE;
        end else begin
          wd_d = wd_q + 12'd1;
        end
`endif
      end
      S_RELEASE: begin
        if (!done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cx0_q   <= '0;
      cy0_q   <= '0;
      cx1_q   <= '0;
      cy1_q   <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      rx0_q   <= '0;
      ry0_q   <= '0;
      rx1_q   <= '0;
      ry1_q   <= '0;
      steep_q <= 1'b0;
      lines_q <= '0;
    end else begin
      state_q <= state_d;
      cx0_q   <= cx0_d;
      cy0_q   <= cy0_d;
      cx1_q   <= cx1_d;
      cy1_q   <= cy1_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      rx0_q   <= rx0_d;
      ry0_q   <= ry0_d;
      rx1_q   <= rx1_d;
      ry1_q   <= ry1_d;
      steep_q <= steep_d;
      lines_q <= lines_d;
    end
  end

`ifdef LINE_SETUP_TIMEOUT_EN
  // Watchdog counter and sticky abort flag
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      wd_q <= '0;
      to_q <= 1'b0;
    end else begin
      wd_q <= wd_d;
      to_q <= to_d;
    end
  end

  assign timeout = to_q;
`else
  assign timeout = 1'b0;
`endif

  assign req_ready   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign stt         = (state_q == S_START) ||
                       (state_q == S_WAIT_DONE);
  assign realx0      = rx0_q;
  assign realy0      = ry0_q;
  assign realx1      = rx1_q;
  assign realy1      = ry1_q;
  assign steep       = steep_q;
  assign lines_drawn = lines_q;

endmodule

// File: tb/tb_line_setup_ctrl.sv
// Directed self-checking bench for line_setup_ctrl.
// Table of endpoint vectors plus hand-written handshake/reset cases.
module tb_line_setup_ctrl;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [8:0] x0, y0, x1, y1;
  logic [8:0] realx0, realy0, realx1, realy1;
  logic       steep;
  logic       stt;
  logic       done;
  logic       busy;
  logic [15:0] lines_drawn;
  logic       timeout;

  int n_chk  = 0;
  int n_pass = 0;
  logic [15:0] exp_lines;

  line_setup_ctrl dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .x0          (x0),
    .y0          (y0),
    .x1          (x1),
    .y1          (y1),
    .realx0      (realx0),
    .realy0      (realy0),
    .realx1      (realx1),
    .realy1      (realy1),
    .steep       (steep),
    .stt         (stt),
    .done        (done),
    .busy        (busy),
    .lines_drawn (lines_drawn),
    .timeout     (timeout)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic [8:0] x0, y0, x1, y1;
    logic       st;
    logic [8:0] ex0, ey0, ex1, ey1;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Present a request at a negedge; return cycles until stt
  task automatic send(input logic [8:0] a, input logic [8:0] b,
                      input logic [8:0] c, input logic [8:0] d,
                      output int lat);
    @(negedge CLOCK_50);
    x0 = a; y0 = b; x1 = c; y1 = d;
    req_valid = 1'b1;
    chk("req_ready_idle", req_ready, 1);
    @(negedge CLOCK_50);
    req_valid = 1'b0;
    lat = 1;
    while (!stt && lat < 10) begin
      @(negedge CLOCK_50);
      lat++;
    end
  endtask

  initial begin
    int lat;
    int n;
    tbl[0] = '{9'd10, 9'd20, 9'd50, 9'd30, 1'b0,
               9'd10, 9'd20, 9'd50, 9'd30};
    tbl[1] = '{9'd50, 9'd30, 9'd10, 9'd20, 1'b0,
               9'd10, 9'd20, 9'd50, 9'd30};
    tbl[2] = '{9'd5, 9'd5, 9'd8, 9'd100, 1'b1,
               9'd5, 9'd5, 9'd100, 9'd8};
    tbl[3] = '{9'd7, 9'd7, 9'd7, 9'd7, 1'b0,
               9'd7, 9'd7, 9'd7, 9'd7};
    tbl[4] = '{9'd0, 9'd0, 9'd9, 9'd9, 1'b0,
               9'd0, 9'd0, 9'd9, 9'd9};
    tbl[5] = '{9'd20, 9'd100, 9'd10, 9'd0, 1'b1,
               9'd0, 9'd10, 9'd100, 9'd20};
    tbl[6] = '{9'd511, 9'd0, 9'd0, 9'd511, 1'b0,
               9'd0, 9'd511, 9'd511, 9'd0};

    reset = 1'b1;
    req_valid = 1'b0;
    done = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    exp_lines = 16'd0;
    #1;
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_stt", stt, 0);
    chk("rst_lines", lines_drawn, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_realx1", realx1, 0);
    repeat (2) @(negedge CLOCK_50);
    reset = 1'b0;

    // done while idle must be ignored
    done = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    chk("idle_done_lines", lines_drawn, 0);
    chk("idle_done_ready", req_ready, 1);
    done = 1'b0;

    for (int i = 0; i < 7; i++) begin
      send(tbl[i].x0, tbl[i].y0, tbl[i].x1, tbl[i].y1, lat);
      chk($sformatf("v%0d_latency", i), lat, 4);
      chk($sformatf("v%0d_steep", i), steep, tbl[i].st);
      chk($sformatf("v%0d_rx0", i), realx0, tbl[i].ex0);
      chk($sformatf("v%0d_ry0", i), realy0, tbl[i].ey0);
      chk($sformatf("v%0d_rx1", i), realx1, tbl[i].ex1);
      chk($sformatf("v%0d_ry1", i), realy1, tbl[i].ey1);
      chk($sformatf("v%0d_busy", i), busy, 1);
      repeat (2) @(negedge CLOCK_50);
      chk($sformatf("v%0d_stt_wait", i), stt, 1);
      done = 1'b1;
      @(negedge CLOCK_50);
      exp_lines = exp_lines + 16'd1;
      chk($sformatf("v%0d_lines", i), lines_drawn, exp_lines);
      chk($sformatf("v%0d_stt_rel", i), stt, 0);
      chk($sformatf("v%0d_hold_rx0", i), realx0, tbl[i].ex0);
      done = 1'b0;
      @(negedge CLOCK_50);
      chk($sformatf("v%0d_ready_back", i), req_ready, 1);
      chk($sformatf("v%0d_idle_busy", i), busy, 0);
    end

    // done held for three cycles counts one line
    send(9'd1, 9'd2, 9'd3, 9'd4, lat);
    chk("hold3_latency", lat, 4);
    @(negedge CLOCK_50);
    done = 1'b1;
    @(negedge CLOCK_50);
    exp_lines = exp_lines + 16'd1;
    chk("hold3_lines_c1", lines_drawn, exp_lines);
    chk("hold3_ready_c1", req_ready, 0);
    @(negedge CLOCK_50);
    chk("hold3_lines_c2", lines_drawn, exp_lines);
    chk("hold3_ready_c2", req_ready, 0);
    @(negedge CLOCK_50);
    done = 1'b0;
    chk("hold3_lines_c3", lines_drawn, exp_lines);
    chk("hold3_ready_c3", req_ready, 0);
    @(negedge CLOCK_50);
    chk("hold3_ready_c4", req_ready, 1);
    chk("hold3_lines_c4", lines_drawn, exp_lines);

    // asynchronous reset in WAIT_DONE
    send(9'd100, 9'd3, 9'd200, 9'd9, lat);
    chk("rstmid_latency", lat, 4);
    @(negedge CLOCK_50);
    chk("rstmid_pre_stt", stt, 1);
    reset = 1'b1;
    #1;
    exp_lines = 16'd0;
    chk("rstmid_stt", stt, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_rx0", realx0, 0);
    chk("rstmid_ry0", realy0, 0);
    chk("rstmid_rx1", realx1, 0);
    chk("rstmid_ry1", realy1, 0);
    chk("rstmid_steep", steep, 0);
    chk("rstmid_lines", lines_drawn, exp_lines);
    chk("rstmid_timeout", timeout, 0);
    @(negedge CLOCK_50);
    reset = 1'b0;
    n = 0;
    repeat (8) begin
      @(negedge CLOCK_50);
      if (stt) n++;
    end
    chk("rstmid_no_stt", n, 0);
    chk("rstmid_ready", req_ready, 1);

`ifdef LINE_SETUP_TIMEOUT_EN
    send(9'd1, 9'd1, 9'd2, 9'd2, lat);
    chk("wd_latency", lat, 4);
    n = 0;
    while (!timeout && n < 5000) begin
      @(negedge CLOCK_50);
      n++;
    end
    chk("wd_cycles", n, 4096);
    chk("wd_timeout", timeout, 1);
    chk("wd_lines", lines_drawn, exp_lines);
    chk("wd_stt", stt, 0);
    @(negedge CLOCK_50);
    chk("wd_ready", req_ready, 1);
    chk("wd_sticky", timeout, 1);
`else
    send(9'd1, 9'd1, 9'd2, 9'd2, lat);
    chk("nowd_latency", lat, 4);
    repeat (20) @(negedge CLOCK_50);
    chk("nowd_still_wait", stt, 1);
    chk("nowd_timeout", timeout, 0);
    done = 1'b1;
    @(negedge CLOCK_50);
    exp_lines = exp_lines + 16'd1;
    chk("nowd_lines", lines_drawn, exp_lines);
    done = 1'b0;
    @(negedge CLOCK_50);
    chk("nowd_ready", req_ready, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/line_setup_ctrl.md
LINE_SETUP_CTRL -- requirements
Module: line_setup_ctrl

Interface
REQ-001 SHALL have port CLOCK_50, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have ports req_valid (input, 1) and req_ready (output, 1), the line-request handshake.
REQ-004 SHALL have ports x0, y0, x1, y1, each input, 9, unsigned raw endpoint coordinates.
REQ-005 SHALL have ports realx0, realy0, realx1, realy1, each output, 9, normalised endpoints to the line engine.
REQ-006 SHALL have port steep, output, 1, octave flag to the line engine.
REQ-007 SHALL have port stt, output, 1, start level to the line engine.
REQ-008 SHALL have port done, input, 1, line engine finished (cmpx asserted).
REQ-009 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-010 SHALL have port lines_drawn, output, 16, count of completed lines.
REQ-011 SHALL have port timeout, output, 1, sticky abort flag (LINE_SETUP_TIMEOUT_EN only).

Function
REQ-012 SHALL accept a request only on a cycle with req_valid=1 and req_ready=1, capturing x0..y1 on that edge.
REQ-013 SHALL drive req_ready=1 only in IDLE.
REQ-014 SHALL implement states IDLE -> CAPTURE -> ABS -> SWAP -> START -> WAIT_DONE -> RELEASE -> IDLE.
REQ-015 SHALL in ABS register |x1-x0| and |y1-y0| as 9-bit unsigned magnitudes.
REQ-016 SHALL set steep=1 when |y1-y0| > |x1-x0| strictly; equal magnitudes give steep=0.
REQ-017 SHALL in SWAP exchange x and y within each endpoint when steep=1, then exchange the endpoints when the resulting x0 > x1.
REQ-018 SHALL hold realx0..realy1 and steep constant from the START entry until RELEASE exit.
REQ-019 SHALL assert stt from START through WAIT_DONE inclusive, and deassert it in RELEASE.
REQ-020 SHALL leave WAIT_DONE on the first cycle with done=1, increment lines_drawn (wrapping 0xFFFF->0x0000), and enter RELEASE.
REQ-021 SHALL remain in RELEASE until done=0, then return to IDLE; minimum one RELEASE cycle.
REQ-022 SHALL process degenerate single-point requests (x0=x1, y0=y1) normally with steep=0 and no endpoint swap.
REQ-023 SHALL ignore done in all states other than WAIT_DONE and RELEASE.
REQ-024 SHALL have acceptance-to-stt latency of exactly 4 cycles (CAPTURE, ABS, SWAP, START).

Reset
REQ-025 SHALL on reset force IDLE, stt=0, steep=0, busy=0, realx0..realy1=0, lines_drawn=0, timeout=0, regardless of current state.
REQ-026 SHALL after reset deasserts mid-line issue no stt until a new request is accepted.

Configuration
REQ-027 SHALL with LINE_SETUP_TIMEOUT_EN defined run a 12-bit watchdog counter in WAIT_DONE; on reaching 4095 cycles without done, enter RELEASE without incrementing lines_drawn and set timeout until reset.
REQ-028 SHALL without LINE_SETUP_TIMEOUT_EN wait in WAIT_DONE indefinitely and tie timeout to 0.

Structure
REQ-029 SHALL place the state encoding, coordinate width (9), counter width (16) and watchdog limit (4095) in shared package lda_pkg.
REQ-030 SHALL implement the steep/swap normalisation as sub-module lda_normalise, registered at the SWAP boundary only in the parent.

Verification
REQ-031 SHALL verify (10,20)->(50,30): steep=0, realx0=10, realy0=20, realx1=50, realy1=30, stt 4 cycles after acceptance.
REQ-032 SHALL verify (50,30)->(10,20): endpoints swapped to realx0=10, realy0=20, realx1=50, realy1=30.
REQ-033 SHALL verify (5,5)->(8,100): steep=1, realx0=5, realy0=5, realx1=100, realy1=8.
REQ-034 SHALL verify done held high 3 cycles then low: lines_drawn +1 once, req_ready returns 1 cycle after done falls.
REQ-035 SHALL verify reset asserted in WAIT_DONE: stt=0 and all outputs zero immediately, without a clock edge.
REQ-036 SHALL verify with LINE_SETUP_TIMEOUT_EN and done held 0: timeout=1 after 4095 WAIT_DONE cycles, lines_drawn unchanged.
